// File: rtl/ps2_key_decoder.sv
// PS/2 Set-2 keyboard front end: filtered frame receiver plus make/break decoder driving held-key levels.
// Build option: define PS2_ARROW_KEYS_EN to also map the E0-prefixed arrow keys.
`default_nettype none

module ps2_key_decoder #(
  parameter int CLK_HZ     = 65_000_000,
  parameter int FILTER_LEN = 8,
  parameter int TIMEOUT_US = 2000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic       stepleft,
  output logic       stepright,
  output logic       stepjump,
  output logic       byte_valid,
  output logic [7:0] byte_data,
  output logic       frame_err
);

  localparam int TO_CYCLES = CLK_HZ / 1_000_000 * TIMEOUT_US;
  localparam int TO_W      = $clog2(TO_CYCLES + 1);
  localparam int FLT_W     = $clog2(FILTER_LEN + 1);

  localparam int K_A  = 0;
  localparam int K_D  = 1;
  localparam int K_W  = 2;
  localparam int K_SP = 3;
`ifdef PS2_ARROW_KEYS_EN
  localparam int K_AL   = 4;
  localparam int K_AR   = 5;
  localparam int K_AU   = 6;
  localparam int N_KEYS = 7;
`else
  localparam int N_KEYS = 4;
`endif

  typedef enum logic [1:0] {S_IDLE, S_DATA, S_PARITY, S_STOP} state_t;

  logic [1:0]       clk_sync_q, dat_sync_q;
  logic             filt_q, fall_q;
  logic [FLT_W-1:0] flt_cnt_q;
  state_t           state_q;
  logic [2:0]       bit_cnt_q;
  logic [7:0]       shift_q;
  logic             par_q;
  logic [TO_W-1:0]  to_cnt_q;
  logic             byte_valid_q, frame_err_q;
  logic [7:0]       byte_data_q;
  logic             ext_q, brk_q, ext_d, brk_d;
  logic [N_KEYS-1:0] held_q, held_d;
  logic             left_q, right_q, jump_q, left_d, right_d, jump_d;
  logic             din;

  assign din = dat_sync_q[1];

  // Synchronisers idle high so that reset never fabricates a falling edge.
  always_ff @(posedge clk) begin
    if (!rst) begin
      clk_sync_q <= 2'b11;
      dat_sync_q <= 2'b11;
      filt_q     <= 1'b1;
      flt_cnt_q  <= '0;
      fall_q     <= 1'b0;
    end else begin
      clk_sync_q <= {clk_sync_q[0], ps2_clk};
      dat_sync_q <= {dat_sync_q[0], ps2_data};
      fall_q     <= 1'b0;
      if (clk_sync_q[1] == filt_q) begin
        flt_cnt_q <= '0;
      end else if (flt_cnt_q == FLT_W'(FILTER_LEN - 1)) begin
        filt_q    <= clk_sync_q[1];
        flt_cnt_q <= '0;
        fall_q    <= filt_q;
      end else begin
        flt_cnt_q <= flt_cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q      <= S_IDLE;
      bit_cnt_q    <= '0;
      shift_q      <= '0;
      par_q        <= 1'b0;
      to_cnt_q     <= '0;
      byte_valid_q <= 1'b0;
      byte_data_q  <= '0;
      frame_err_q  <= 1'b0;
    end else begin
      byte_valid_q <= 1'b0;
      frame_err_q  <= 1'b0;
      if (state_q != S_IDLE && !fall_q && to_cnt_q == TO_W'(TO_CYCLES - 1)) begin
        state_q     <= S_IDLE;
        to_cnt_q    <= '0;
        frame_err_q <= 1'b1;
      end else begin
        if (state_q == S_IDLE || fall_q) to_cnt_q <= '0;
        else                             to_cnt_q <= to_cnt_q + 1'b1;
        if (fall_q) begin
          case (state_q)
            S_IDLE: begin
              if (!din) begin
                state_q   <= S_DATA;
                bit_cnt_q <= '0;
              end
            end
            S_DATA: begin
              shift_q   <= {din, shift_q[7:1]};
              bit_cnt_q <= bit_cnt_q + 1'b1;
              if (bit_cnt_q == 3'd7) state_q <= S_PARITY;
            end
            S_PARITY: begin
              par_q   <= din;
              state_q <= S_STOP;
            end
            default: begin
              state_q <= S_IDLE;
              if (din && (^{shift_q, par_q})) begin
                byte_valid_q <= 1'b1;
                byte_data_q  <= shift_q;
              end else begin
                frame_err_q <= 1'b1;
              end
            end
          endcase
        end
      end
    end
  end

  always_comb begin
    ext_d  = ext_q;
    brk_d  = brk_q;
    held_d = held_q;
    if (frame_err_q) begin
      ext_d = 1'b0;
      brk_d = 1'b0;
    end else if (byte_valid_q) begin
      if (byte_data_q == 8'hE0) begin
        ext_d = 1'b1;
      end else if (byte_data_q == 8'hF0) begin
        brk_d = 1'b1;
      end else begin
        if (!ext_q) begin
          case (byte_data_q)
            8'h1C:   held_d[K_A]  = !brk_q;
            8'h23:   held_d[K_D]  = !brk_q;
            8'h1D:   held_d[K_W]  = !brk_q;
            8'h29:   held_d[K_SP] = !brk_q;
            default: ;
          endcase
        end
`ifdef PS2_ARROW_KEYS_EN
        else begin
          case (byte_data_q)
            8'h6B:   held_d[K_AL] = !brk_q;
            8'h74:   held_d[K_AR] = !brk_q;
            8'h75:   held_d[K_AU] = !brk_q;
            default: ;
          endcase
        end
`endif
        ext_d = 1'b0;
        brk_d = 1'b0;
      end
    end
  end

  always_comb begin
    left_d  = held_d[K_A];
    right_d = held_d[K_D];
    jump_d  = held_d[K_W] | held_d[K_SP];
`ifdef PS2_ARROW_KEYS_EN
    left_d  = left_d  | held_d[K_AL];
    right_d = right_d | held_d[K_AR];
    jump_d  = jump_d  | held_d[K_AU];
`endif
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      ext_q   <= 1'b0;
      brk_q   <= 1'b0;
      held_q  <= '0;
      left_q  <= 1'b0;
      right_q <= 1'b0;
      jump_q  <= 1'b0;
    end else begin
      ext_q   <= ext_d;
      brk_q   <= brk_d;
      held_q  <= held_d;
      left_q  <= left_d;
      right_q <= right_d;
      jump_q  <= jump_d;
    end
  end

  assign stepleft   = left_q;
  assign stepright  = right_q;
  assign stepjump   = jump_q;
  assign byte_valid = byte_valid_q;
  assign byte_data  = byte_data_q;
  assign frame_err  = frame_err_q;

endmodule

`default_nettype wire

// File: tb/tb_ps2_key_decoder.sv
// Scoreboard bench for ps2_key_decoder: frames driven at a scaled-down clock rate.
`default_nettype none

module tb_ps2_key_decoder;

  localparam int CLK_HZ     = 1_000_000;
  localparam int FILTER_LEN = 8;
  localparam int TIMEOUT_US = 200;
  localparam int HALF       = 20;
  localparam int GAP        = 40;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       ps2_clk = 1'b1;
  logic       ps2_data = 1'b1;
  logic       stepleft, stepright, stepjump, byte_valid, frame_err;
  logic [7:0] byte_data;

  typedef struct {
    bit         is_err;
    logic [7:0] data;
  } evt_t;

  evt_t       sb[$];
  logic [7:0] last_good = 8'h00;
  int         n_checks = 0;
  int         n_errors = 0;

  ps2_key_decoder #(
    .CLK_HZ    (CLK_HZ),
    .FILTER_LEN(FILTER_LEN),
    .TIMEOUT_US(TIMEOUT_US)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .ps2_clk   (ps2_clk),
    .ps2_data  (ps2_data),
    .stepleft  (stepleft),
    .stepright (stepright),
    .stepjump  (stepjump),
    .byte_valid(byte_valid),
    .byte_data (byte_data),
    .frame_err (frame_err)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic send_frame(input logic [7:0] b, input bit bad_par, input bit stop_bit, input int nbits);
    logic [10:0] fr;
    fr = {stop_bit, (~^b) ^ bad_par, b, 1'b0};
    for (int i = 0; i < nbits; i++) begin
      ps2_data = fr[i];
      tick(HALF);
      ps2_clk = 1'b0;
      tick(HALF);
      ps2_clk = 1'b1;
    end
    ps2_data = 1'b1;
    tick(GAP);
  endtask

  task automatic send_key(input logic [7:0] b);
    sb.push_back('{is_err: 1'b0, data: b});
    last_good = b;
    send_frame(b, 1'b0, 1'b1, 11);
  endtask

  task automatic send_bad(input logic [7:0] b, input bit bad_par, input bit stop_bit);
    sb.push_back('{is_err: 1'b1, data: last_good});
    send_frame(b, bad_par, stop_bit, 11);
  endtask

  task automatic check_steps(input string tag, input bit l, input bit r, input bit j);
    check_val({tag, "_left"},  {31'd0, stepleft},  {31'd0, l});
    check_val({tag, "_right"}, {31'd0, stepright}, {31'd0, r});
    check_val({tag, "_jump"},  {31'd0, stepjump},  {31'd0, j});
  endtask

  // Compares every DUT byte/error pulse against the oldest expected event.
  initial begin
    evt_t e;
    forever begin
      @(posedge clk);
      #1;
      if (byte_valid || frame_err) begin
        if (sb.size() == 0) begin
          check_val("spurious_evt", {30'd0, byte_valid, frame_err}, 32'd0);
        end else begin
          e = sb.pop_front();
          check_val("evt_kind", {30'd0, byte_valid, frame_err}, e.is_err ? 32'd1 : 32'd2);
          check_val("evt_data", {24'd0, byte_data}, {24'd0, e.data});
        end
      end
    end
  end

  initial begin
    rst = 1'b0;
    tick(5);
    check_steps("reset", 1'b0, 1'b0, 1'b0);
    check_val("reset_valid", {31'd0, byte_valid}, 32'd0);
    check_val("reset_data",  {24'd0, byte_data},  32'd0);
    check_val("reset_err",   {31'd0, frame_err},  32'd0);
    rst = 1'b1;
    tick(5);

    send_key(8'h1C);
    check_steps("make_a", 1'b1, 1'b0, 1'b0);
    send_key(8'hF0);
    send_key(8'h1C);
    check_steps("break_a", 1'b0, 1'b0, 1'b0);
    send_key(8'h23);
    check_steps("make_d", 1'b0, 1'b1, 1'b0);

    send_key(8'h29);
    send_key(8'h1D);
    send_key(8'hF0);
    send_key(8'h29);
    check_steps("jump_w_held", 1'b0, 1'b1, 1'b1);
    send_key(8'hF0);
    send_key(8'h1D);
    check_steps("jump_rel", 1'b0, 1'b1, 1'b0);

    send_key(8'h1C);
    send_key(8'h1C);
    check_steps("typematic", 1'b1, 1'b1, 1'b0);
    send_bad(8'h1C, 1'b1, 1'b1);
    check_steps("bad_parity", 1'b1, 1'b1, 1'b0);
    send_key(8'hF0);
    send_bad(8'h1C, 1'b0, 1'b0);
    send_key(8'h1C);
    check_steps("err_clears_brk", 1'b1, 1'b1, 1'b0);
    send_key(8'hF0);
    send_key(8'h1C);
    send_key(8'hF0);
    send_key(8'h23);
    check_steps("both_released", 1'b0, 1'b0, 1'b0);

    sb.push_back('{is_err: 1'b1, data: last_good});
    send_frame(8'h23, 1'b0, 1'b1, 5);
    tick(TIMEOUT_US * 2);
    send_key(8'h23);
    check_steps("after_timeout", 1'b0, 1'b1, 1'b0);

`ifdef PS2_ARROW_KEYS_EN
    send_key(8'hE0);
    send_key(8'h6B);
    check_steps("arrow_left", 1'b1, 1'b1, 1'b0);
    send_key(8'hE0);
    send_key(8'hF0);
    send_key(8'h6B);
    check_steps("arrow_rel", 1'b0, 1'b1, 1'b0);
`else
    send_key(8'hE0);
    send_key(8'h6B);
    check_steps("arrow_ignored", 1'b0, 1'b1, 1'b0);
`endif
    send_key(8'h1C);
    check_steps("left_and_right", 1'b1, 1'b1, 1'b0);

    ps2_data = 1'b0;
    ps2_clk = 1'b0;
    tick(FILTER_LEN - 1);
    ps2_clk = 1'b1;
    tick(HALF);
    ps2_clk = 1'b0;
    tick(1);
    ps2_clk = 1'b1;
    tick(TIMEOUT_US * 2);
    ps2_data = 1'b1;
    tick(GAP);
    check_steps("glitch", 1'b1, 1'b1, 1'b0);

    send_frame(8'h29, 1'b0, 1'b1, 6);
    rst = 1'b0;
    tick(3);
    check_steps("mid_reset", 1'b0, 1'b0, 1'b0);
    check_val("mid_reset_data", {24'd0, byte_data}, 32'd0);
    rst = 1'b1;
    last_good = 8'h00;
    tick(TIMEOUT_US * 2);
    send_key(8'h1D);
    check_steps("post_reset", 1'b0, 1'b0, 1'b1);

    tick(GAP);
    check_val("sb_empty", sb.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

endmodule

`default_nettype wire
